// File: rtl/ntr_cmd_capture.sv
// NTR cartridge bus capture: synchronizes the asynchronous NTR pins into the clk domain
// and assembles the bytes of one chip-select frame into a command word.
module ntr_cmd_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int CMD_BYTES   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ntr_clk_i,
  input  logic                   ntr_cs1_i,
  input  logic [7:0]             ntr_data_i,
  output logic [8*CMD_BYTES-1:0] cmd_o,
  output logic                   cmd_valid_o,
  output logic                   frame_err_o,
  output logic [7:0]             err_count_o,
  output logic                   busy_o
);

  localparam int CMDW = 8 * CMD_BYTES;
  localparam int CW   = $clog2(CMD_BYTES + 1);
  localparam int FW   = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CMD_BYTES);
  localparam logic [FW-1:0] FILL_DONE = FW'(SYNC_STAGES);

  typedef enum logic [1:0] {
    HUNT,
    IDLE,
    RECV
  } state_t;

  logic [SYNC_STAGES-1:0]      clk_sync_q;
  logic [SYNC_STAGES-1:0]      cs_sync_q;
  logic [SYNC_STAGES-1:0][7:0] data_sync_q;
  logic                        clk_hist_q;
  logic                        cs_hist_q;

  logic                        clk_s;
  logic                        cs_s;
  logic [7:0]                  data_s;
  logic                        clk_rise;
  logic                        cs_fall;
  logic                        cs_rise;

  state_t                      state_q, state_d;
  logic [FW-1:0]               fill_q, fill_d;
  logic [CMDW-1:0]             sr_q, sr_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        ovf_q, ovf_d;
  logic [CMDW-1:0]             cmd_q, cmd_d;
  logic                        cmd_valid_q, cmd_valid_d;
  logic                        frame_err_q, frame_err_d;
  logic [7:0]                  err_q, err_d;
  logic [CMDW+7:0]             sr_shift;

  // Synchronizer chains plus one history flop on clock and chip select for edge detection.
  // Clock and cs1 reset to their idle-high level so reset never fabricates an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q  <= '1;
      cs_sync_q   <= '1;
      data_sync_q <= '0;
      clk_hist_q  <= 1'b1;
      cs_hist_q   <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ntr_clk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], ntr_cs1_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ntr_data_i};
      clk_hist_q  <= clk_s;
      cs_hist_q   <= cs_s;
    end
  end

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign data_s   = data_sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_hist_q;
  assign cs_fall  = ~cs_s & cs_hist_q;
  assign cs_rise  = cs_s & ~cs_hist_q;
  assign sr_shift = {sr_q, data_s};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= HUNT;
      fill_q      <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      err_q       <= err_d;
    end
  end

  // HUNT first lets the synchronizer refill with real samples, because the reset value of
  // cs1 would otherwise look idle and let a frame already in progress be captured.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    err_d       = err_q;
    case (state_q)
      HUNT: begin
        if (fill_q != FILL_DONE) begin
          fill_d = fill_q + FW'(1);
        end else if (cs_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          sr_d    = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = RECV;
        end
      end
      RECV: begin
        // A clock rise coinciding with the cs rise is dropped; the frame closes as counted.
        if (cs_rise) begin
          state_d = IDLE;
          if (cnt_q == CNT_FULL && !ovf_q) begin
            cmd_d       = sr_q;
            cmd_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            if (err_q != 8'hFF) begin
              err_d = err_q + 8'd1;
            end
          end
        end else if (clk_rise && !cs_s) begin
          if (cnt_q == CNT_FULL) begin
            ovf_d = 1'b1;
          end else begin
            sr_d  = sr_shift[CMDW-1:0];
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  assign cmd_o       = cmd_q;
  assign cmd_valid_o = cmd_valid_q;
  assign frame_err_o = frame_err_q;
  assign err_count_o = err_q;
  assign busy_o      = (state_q == RECV);

endmodule

// File: tb/tb_ntr_cmd_capture.sv
// Self-checking bench for ntr_cmd_capture: drives NTR frames and compares against a
// frame-level model (byte count decides valid/error, bytes packed big-endian).
module tb_ntr_cmd_capture;

  localparam int SYNC = 2;
  localparam int NB   = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ntr_clk = 1'b1;
  logic            ntr_cs1 = 1'b1;
  logic [7:0]      ntr_data = 8'h00;
  logic [8*NB-1:0] cmd;
  logic            cmd_valid;
  logic            frame_err;
  logic [7:0]      err_count;
  logic            busy;

  always #5 clk = ~clk;

  ntr_cmd_capture #(.SYNC_STAGES(SYNC), .CMD_BYTES(NB)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ntr_clk_i   (ntr_clk),
    .ntr_cs1_i   (ntr_cs1),
    .ntr_data_i  (ntr_data),
    .cmd_o       (cmd),
    .cmd_valid_o (cmd_valid),
    .frame_err_o (frame_err),
    .err_count_o (err_count),
    .busy_o      (busy)
  );

  int checks = 0;
  int errors = 0;

  // Pulse monitor sampled away from the active edge
  int   valid_pulses = 0;
  int   err_pulses   = 0;
  int   overlap      = 0;
  int   wide         = 0;
  logic prev_v = 1'b0;
  logic prev_e = 1'b0;

  always @(negedge clk) begin
    if (cmd_valid) valid_pulses++;
    if (frame_err) err_pulses++;
    if (cmd_valid && frame_err) overlap++;
    if ((cmd_valid && prev_v) || (frame_err && prev_e)) wide++;
    prev_v = cmd_valid;
    prev_e = frame_err;
  end

  // Reference model
  logic [63:0] exp_cmd = 64'h0;
  int          exp_err = 0;
  logic [7:0]  fb [16];

  function automatic void model_frame(input int n);
    if (n == NB) begin
      exp_cmd = 64'h0;
      for (int i = 0; i < NB; i++)
        exp_cmd = exp_cmd + ({56'h0, fb[i]} * (64'h1 << (8 * (NB - 1 - i))));
    end else begin
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    end
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ntr_clk  = 1'b0;
    ntr_data = b;
    cycles(5);
    ntr_clk  = 1'b1;
    cycles(4);
  endtask

  task automatic run_frame(input int n, input int gap);
    ntr_cs1 = 1'b0;
    cycles(4);
    for (int i = 0; i < n; i++) send_byte(fb[i]);
    ntr_cs1 = 1'b1;
    cycles(gap);
    model_frame(n);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cycles(3);
    @(negedge clk);
    checks++; if (cmd !== 64'h0) begin errors++; $display("[TB] FAIL reset_cmd: got %h expected 0", cmd); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", cmd_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b expected 0", frame_err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_errcnt: got %0d expected 0", err_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(6);
  endtask

  task automatic test_valid_frame;
    int v0, e0;
    v0 = valid_pulses; e0 = err_pulses;
    fb[0] = 8'hFF; for (int i = 1; i < 7; i++) fb[i] = 8'h00; fb[7] = 8'h01;
    ntr_cs1 = 1'b0;
    cycles(4);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL valid_busy_in_frame: got %b expected 1", busy); end
    @(posedge clk); #1;
    for (int i = 0; i < NB; i++) send_byte(fb[i]);
    ntr_cs1 = 1'b1;
    cycles(8);
    model_frame(NB);
    @(negedge clk);
    checks++; if (cmd !== exp_cmd || exp_cmd !== 64'hFF00000000000001) begin errors++; $display("[TB] FAIL valid_cmd: got %h expected FF00000000000001", cmd); end
    checks++; if (valid_pulses - v0 !== 1) begin errors++; $display("[TB] FAIL valid_pulses: got %0d expected 1", valid_pulses - v0); end
    checks++; if (err_pulses - e0 !== 0) begin errors++; $display("[TB] FAIL valid_err_pulses: got %0d expected 0", err_pulses - e0); end
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("[TB] FAIL valid_errcnt: got %0d expected %0d", err_count, exp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL valid_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_short_frame;
    int v0, e0;
    v0 = valid_pulses; e0 = err_pulses;
    fb[0] = 8'hAA; fb[1] = 8'hBB; fb[2] = 8'hCC; fb[3] = 8'hDD;
    run_frame(4, 8);
    @(negedge clk);
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("[TB] FAIL short_err_pulses: got %0d expected 1", err_pulses - e0); end
    checks++; if (valid_pulses - v0 !== 0) begin errors++; $display("[TB] FAIL short_valid_pulses: got %0d expected 0", valid_pulses - v0); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("[TB] FAIL short_errcnt: got %0d expected 1", err_count); end
    checks++; if (cmd !== exp_cmd) begin errors++; $display("[TB] FAIL short_cmd_held: got %h expected %h", cmd, exp_cmd); end
  endtask

  task automatic test_long_frame;
    int v0, e0;
    v0 = valid_pulses; e0 = err_pulses;
    for (int i = 0; i < 9; i++) fb[i] = 8'(i + 1);
    run_frame(9, 8);
    @(negedge clk);
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("[TB] FAIL long_err_pulses: got %0d expected 1", err_pulses - e0); end
    checks++; if (valid_pulses - v0 !== 0) begin errors++; $display("[TB] FAIL long_valid_pulses: got %0d expected 0", valid_pulses - v0); end
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("[TB] FAIL long_errcnt: got %0d expected %0d", err_count, exp_err); end
    fb[0] = 8'h9F; for (int i = 1; i < NB; i++) fb[i] = 8'h00;
    v0 = valid_pulses;
    run_frame(NB, 8);
    @(negedge clk);
    checks++; if (cmd !== 64'h9F00000000000000) begin errors++; $display("[TB] FAIL long_next_cmd: got %h expected 9F00000000000000", cmd); end
    checks++; if (valid_pulses - v0 !== 1) begin errors++; $display("[TB] FAIL long_next_valid: got %0d expected 1", valid_pulses - v0); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, e0;
    fill_random(NB);
    ntr_cs1 = 1'b0;
    cycles(4);
    for (int i = 0; i < 3; i++) send_byte(fb[i]);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    exp_err = 0;
    exp_cmd = 64'h0;
    v0 = valid_pulses; e0 = err_pulses;
    for (int i = 3; i < NB; i++) send_byte(fb[i]);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    ntr_cs1 = 1'b1;
    cycles(8);
    @(negedge clk);
    checks++; if (valid_pulses - v0 !== 0) begin errors++; $display("[TB] FAIL midrst_valid: got %0d expected 0", valid_pulses - v0); end
    checks++; if (err_pulses - e0 !== 0) begin errors++; $display("[TB] FAIL midrst_err: got %0d expected 0", err_pulses - e0); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL midrst_errcnt: got %0d expected 0", err_count); end
    checks++; if (cmd !== 64'h0) begin errors++; $display("[TB] FAIL midrst_cmd: got %h expected 0", cmd); end
    fill_random(NB);
    v0 = valid_pulses;
    @(posedge clk); #1;
    run_frame(NB, 8);
    @(negedge clk);
    checks++; if (cmd !== exp_cmd) begin errors++; $display("[TB] FAIL midrst_next_cmd: got %h expected %h", cmd, exp_cmd); end
    checks++; if (valid_pulses - v0 !== 1) begin errors++; $display("[TB] FAIL midrst_next_valid: got %0d expected 1", valid_pulses - v0); end
  endtask

  task automatic test_idle_noise;
    int v0, e0;
    v0 = valid_pulses; e0 = err_pulses;
    for (int i = 0; i < 10; i++) begin
      ntr_clk  = 1'b0;
      ntr_data = 8'($urandom);
      cycles(3);
      ntr_clk  = 1'b1;
      cycles(3);
    end
    run_frame(0, 8);
    @(negedge clk);
    checks++; if (valid_pulses - v0 !== 0) begin errors++; $display("[TB] FAIL noise_valid: got %0d expected 0", valid_pulses - v0); end
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("[TB] FAIL noise_err: got %0d expected 1", err_pulses - e0); end
    checks++; if (err_count !== 8'(exp_err) || exp_err !== 1) begin errors++; $display("[TB] FAIL noise_errcnt: got %0d expected 1", err_count); end
  endtask

  task automatic test_random_frames;
    int v0, e0, n, ev, ee;
    for (int k = 0; k < 16; k++) begin
      n = ($urandom_range(0, 1) == 1) ? NB : int'($urandom_range(0, 10));
      fill_random(n);
      ev = (n == NB) ? 1 : 0;
      ee = 1 - ev;
      v0 = valid_pulses; e0 = err_pulses;
      run_frame(n, 8);
      @(negedge clk);
      checks++; if (valid_pulses - v0 !== ev || err_pulses - e0 !== ee) begin errors++; $display("[TB] FAIL rand_pulses len=%0d: got v=%0d e=%0d expected v=%0d e=%0d", n, valid_pulses - v0, err_pulses - e0, ev, ee); end
      checks++; if (cmd !== exp_cmd) begin errors++; $display("[TB] FAIL rand_cmd len=%0d: got %h expected %h", n, cmd, exp_cmd); end
      checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("[TB] FAIL rand_errcnt: got %0d expected %0d", err_count, exp_err); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    int v0, e0;
    int lens [4] = '{NB, 3, NB, NB};
    v0 = valid_pulses; e0 = err_pulses;
    for (int k = 0; k < 4; k++) begin
      fill_random(lens[k]);
      run_frame(lens[k], (k == 3) ? 8 : 2);
    end
    @(negedge clk);
    checks++; if (valid_pulses - v0 !== 3) begin errors++; $display("[TB] FAIL b2b_valid: got %0d expected 3", valid_pulses - v0); end
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("[TB] FAIL b2b_err: got %0d expected 1", err_pulses - e0); end
    checks++; if (cmd !== exp_cmd) begin errors++; $display("[TB] FAIL b2b_cmd: got %h expected %h", cmd, exp_cmd); end
    checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("[TB] FAIL b2b_errcnt: got %0d expected %0d", err_count, exp_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation;
    int v0, e0;
    logic [63:0] held;
    held = exp_cmd;
    v0 = valid_pulses; e0 = err_pulses;
    for (int k = 0; k < 260; k++) run_frame(0, 4);
    cycles(4);
    @(negedge clk);
    checks++; if (err_count !== 8'd255 || exp_err !== 255) begin errors++; $display("[TB] FAIL sat_errcnt: got %0d expected 255", err_count); end
    checks++; if (err_pulses - e0 !== 260) begin errors++; $display("[TB] FAIL sat_err_pulses: got %0d expected 260", err_pulses - e0); end
    checks++; if (valid_pulses - v0 !== 0) begin errors++; $display("[TB] FAIL sat_valid: got %0d expected 0", valid_pulses - v0); end
    checks++; if (cmd !== held) begin errors++; $display("[TB] FAIL sat_cmd_held: got %h expected %h", cmd, held); end
  endtask

  task automatic test_pulse_shape;
    checks++; if (overlap !== 0) begin errors++; $display("[TB] FAIL pulse_overlap: got %0d expected 0", overlap); end
    checks++; if (wide !== 0) begin errors++; $display("[TB] FAIL pulse_width: got %0d expected 0", wide); end
  endtask

  initial begin
    $display("[TB] starting ntr_cmd_capture bench");
    test_reset;
    test_valid_frame;
    test_short_frame;
    test_long_frame;
    test_reset_mid_frame;
    test_idle_noise;
    test_random_frames;
    test_back_to_back;
    test_saturation;
    test_pulse_shape;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
